// File: rtl/spi_master_param_pkg.sv
// Shared types and constants for the parametrised SPI master.
// Holds the transfer-sequencer state encoding and the default read opcode.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SETUP    = 3'd2,
    TX       = 3'd3,
    RX       = 3'd4,
    HOLD     = 3'd5
  } spi_state_e;

  localparam logic [1:0] RD_OPC_DEF = 2'b11;

endpackage

// File: rtl/spi_master_param_if.sv
// Request/response bus between a controller and the SPI master.
// The controller drives requests through 'master'; the SPI block uses 'slave'.
interface spi_master_param_if #(
  parameter int CMD_W = 10,
  parameter int RD_W  = 8,
  parameter int SEL_W = 1
);

  logic             req_valid;
  logic             req_ready;
  logic [CMD_W-1:0] cmd_data;
  logic [SEL_W-1:0] ss_sel;
  logic             busy;
  logic             done;
  logic             rd_valid;
  logic [RD_W-1:0]  rd_data;
  logic             err_timeout;

  modport master (
    output req_valid, cmd_data, ss_sel,
    input  req_ready, busy, done, rd_valid, rd_data, err_timeout
  );

  modport slave (
    input  req_valid, cmd_data, ss_sel,
    output req_ready, busy, done, rd_valid, rd_data, err_timeout
  );

endinterface

// File: rtl/spi_master_param_sclk_gen.sv
// SCLK divider: toggles sclk every DIV enabled cycles and flags the cycle
// on whose closing edge sclk will rise or fall. clr forces sclk low and restarts.
module spi_sclk_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic          sclk_r;
  logic          wrap_s;

  // Strobes depend only on state and enable, never on clr, so the caller may use them to build clr.
  assign wrap_s   = en && (cnt_r == CW'(DIV - 1));
  assign rise_stb = wrap_s && !sclk_r;
  assign fall_stb = wrap_s && sclk_r;
  assign sclk     = sclk_r;

  // Half-period counter and SCLK toggle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      sclk_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {CW{1'b0}};
      sclk_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= {CW{1'b0}};
      sclk_r <= ~sclk_r;
    end else if (en) begin
      cnt_r  <= cnt_r + CW'(1);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised mode-0 SPI master: waits for sready, shifts out a CMD_W command,
// optionally shifts in an RD_W response, then releases the slave select.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int         CMD_W   = 10,
  parameter int         RD_W    = 8,
  parameter int         NUM_SS  = 1,
  parameter int         DIV     = 2,
  parameter logic [1:0] RD_OPC  = RD_OPC_DEF,
  parameter int         TIMEOUT = 255,
  parameter int         SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_param_if.slave bus,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  input  logic              miso,
  input  logic              sready
);

  localparam int MAXB   = (CMD_W > RD_W) ? CMD_W : RD_W;
  localparam int CNT_W  = $clog2(MAXB + 1);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  spi_state_e        state_r;
  logic [CMD_W-1:0]  cmd_sh_r;
  logic [SEL_W-1:0]  sel_r;
  logic [SEL_W-1:0]  sel_eff_s;
  logic              is_read_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [RD_W-1:0]   rx_sh_r;
  logic [RD_W-1:0]   rd_data_r;
  logic [NUM_SS-1:0] ss_n_r;
  logic              mosi_r;
  logic              busy_r;
  logic              done_r;
  logic              rd_valid_r;
  logic              err_r;
  logic              req_ready_r;
  logic              gen_en_s;
  logic              gen_clr_s;
  logic              sclk_s;
  logic              rise_stb_s;
  logic              fall_stb_s;

  spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (gen_en_s),
    .clr      (gen_clr_s),
    .sclk     (sclk_s),
    .rise_stb (rise_stb_s),
    .fall_stb (fall_stb_s)
  );

  assign sclk            = sclk_s;
  assign mosi            = mosi_r;
  assign ss_n            = ss_n_r;
  assign bus.req_ready   = req_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_data     = rd_data_r;
  assign bus.err_timeout = err_r;

  // Out-of-range slave indices fall back to slave 0.
  always_comb begin
    sel_eff_s = {SEL_W{1'b0}};
    if (32'(bus.ss_sel) < 32'(NUM_SS)) begin
      sel_eff_s = bus.ss_sel;
    end else begin
      sel_eff_s = {SEL_W{1'b0}};
    end
  end

  // Divider control: a suppressed rise marks the end of the last data period and of HOLD.
  always_comb begin
    gen_en_s  = 1'b0;
    gen_clr_s = 1'b1;
    case (state_r)
      SETUP: begin
        gen_en_s  = 1'b1;
        gen_clr_s = 1'b0;
      end
      TX: begin
        gen_en_s = 1'b1;
        if (rise_stb_s && (bit_cnt_r == CNT_W'(CMD_W)) && !is_read_r) begin
          gen_clr_s = 1'b1;
        end else begin
          gen_clr_s = 1'b0;
        end
      end
      RX: begin
        gen_en_s = 1'b1;
        if (rise_stb_s && (bit_cnt_r == CNT_W'(RD_W))) begin
          gen_clr_s = 1'b1;
        end else begin
          gen_clr_s = 1'b0;
        end
      end
      HOLD: begin
        gen_en_s  = 1'b1;
        gen_clr_s = rise_stb_s;
      end
      default: begin
        gen_en_s  = 1'b0;
        gen_clr_s = 1'b1;
      end
    endcase
  end

  // Transfer sequencer with registered bus and SPI pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cmd_sh_r    <= {CMD_W{1'b0}};
      sel_r       <= {SEL_W{1'b0}};
      is_read_r   <= 1'b0;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      rx_sh_r     <= {RD_W{1'b0}};
      rd_data_r   <= {RD_W{1'b0}};
      ss_n_r      <= {NUM_SS{1'b1}};
      mosi_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            cmd_sh_r    <= bus.cmd_data;
            sel_r       <= sel_eff_s;
            is_read_r   <= (bus.cmd_data[CMD_W-1 -: 2] == RD_OPC);
            wait_cnt_r  <= {WAIT_W{1'b0}};
            busy_r      <= 1'b1;
            req_ready_r <= 1'b0;
            state_r     <= WAIT_RDY;
          end else begin
            state_r     <= IDLE;
          end
        end
        WAIT_RDY: begin
          if (sready) begin
            ss_n_r  <= ~(NUM_SS'(1'b1) << sel_r);
            mosi_r  <= cmd_sh_r[CMD_W-1];
            state_r <= SETUP;
          end else if ((TIMEOUT != 0) && (wait_cnt_r == WAIT_W'(TIMEOUT - 1))) begin
            err_r       <= 1'b1;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            wait_cnt_r  <= wait_cnt_r + WAIT_W'(1);
          end
        end
        SETUP: begin
          if (rise_stb_s) begin
            bit_cnt_r <= CNT_W'(1);
            state_r   <= TX;
          end else begin
            state_r   <= SETUP;
          end
        end
        TX: begin
          // Zeros shift in behind the command, so mosi idles low after the last bit.
          if (fall_stb_s) begin
            mosi_r   <= cmd_sh_r[CMD_W-2];
            cmd_sh_r <= {cmd_sh_r[CMD_W-2:0], 1'b0};
          end else if (rise_stb_s) begin
            if (bit_cnt_r == CNT_W'(CMD_W)) begin
              mosi_r <= 1'b0;
              if (is_read_r) begin
                rx_sh_r   <= RD_W'({rx_sh_r, miso});
                bit_cnt_r <= CNT_W'(1);
                state_r   <= RX;
              end else begin
                state_r   <= HOLD;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= TX;
          end
        end
        RX: begin
          if (rise_stb_s) begin
            if (bit_cnt_r == CNT_W'(RD_W)) begin
              state_r   <= HOLD;
            end else begin
              rx_sh_r   <= RD_W'({rx_sh_r, miso});
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= RX;
          end
        end
        HOLD: begin
          if (rise_stb_s) begin
            ss_n_r      <= {NUM_SS{1'b1}};
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
            if (is_read_r) begin
              rd_data_r  <= rx_sh_r;
              rd_valid_r <= 1'b1;
            end else begin
              rd_data_r  <= rd_data_r;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          ss_n_r      <= {NUM_SS{1'b1}};
          mosi_r      <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Randomised self-checking bench for spi_master_param: two configurations,
// a behavioural SPI slave and a transaction-level reference model.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_v;
  logic [15:0] cmd_drv;
  logic [1:0]  sel_drv;
  logic        sready;
  logic        miso;
  logic        sclk_a, mosi_a, sclk_b, mosi_b;
  logic [3:0]  ss_a;
  logic [0:0]  ss_b;

  int          cur;
  int          n_vec;
  int          n_err;
  logic [15:0] last_rd [2];

  logic        o_ready, o_busy, o_done, o_rdv, o_err, o_sclk, o_mosi;
  logic [15:0] o_rd;
  logic [3:0]  o_ss;

  logic [15:0] slv_resp;
  int          slv_cw, slv_rw, slv_rises;
  bit          mosi_q [$];

  always #5 clk = ~clk;

  spi_master_param_if #(.CMD_W(10), .RD_W(8),  .SEL_W(2)) bus_a ();
  spi_master_param_if #(.CMD_W(16), .RD_W(16), .SEL_W(1)) bus_b ();

  assign bus_a.req_valid = req_v[0];
  assign bus_a.cmd_data  = cmd_drv[9:0];
  assign bus_a.ss_sel    = sel_drv;
  assign bus_b.req_valid = req_v[1];
  assign bus_b.cmd_data  = cmd_drv;
  assign bus_b.ss_sel    = sel_drv[0];

  spi_master_param #(.CMD_W(10), .RD_W(8), .NUM_SS(4), .DIV(2), .TIMEOUT(8), .SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .sclk(sclk_a), .mosi(mosi_a),
    .ss_n(ss_a), .miso(miso), .sready(sready)
  );

  spi_master_param #(.CMD_W(16), .RD_W(16), .NUM_SS(1), .DIV(1), .SEL_W(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .sclk(sclk_b), .mosi(mosi_b),
    .ss_n(ss_b), .miso(miso), .sready(sready)
  );

  assign o_ready = (cur == 1) ? bus_b.req_ready   : bus_a.req_ready;
  assign o_busy  = (cur == 1) ? bus_b.busy        : bus_a.busy;
  assign o_done  = (cur == 1) ? bus_b.done        : bus_a.done;
  assign o_rdv   = (cur == 1) ? bus_b.rd_valid    : bus_a.rd_valid;
  assign o_err   = (cur == 1) ? bus_b.err_timeout : bus_a.err_timeout;
  assign o_rd    = (cur == 1) ? bus_b.rd_data     : {8'h00, bus_a.rd_data};
  assign o_sclk  = (cur == 1) ? sclk_b            : sclk_a;
  assign o_mosi  = (cur == 1) ? mosi_b            : mosi_a;
  assign o_ss    = (cur == 1) ? {3'b111, ss_b}    : ss_a;

  // Mode-0 slave: record mosi on every rise, present the response after the command.
  always @(posedge o_sclk) begin
    mosi_q.push_back(o_mosi);
    slv_rises = slv_rises + 1;
  end

  always @(negedge o_sclk) begin
    if (slv_rises >= slv_cw && slv_rises < slv_cw + slv_rw)
      miso = slv_resp[slv_rw - 1 - (slv_rises - slv_cw)];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_xfer(input int d, input logic [15:0] cmd, input logic [1:0] sel,
                          input logic [15:0] resp, input bit inject);
    int cw, rw, dv, nss, eff, exp_done, n_rise, lim;
    int ss_first, ss_last, bad_ss, done_cyc, done_cnt, rdv_cnt, err_cnt;
    bit rd;
    logic [3:0]  exp_ss;
    logic [31:0] exp_w, got_w;
    logic [15:0] exp_rd, mask_c, mask_r;
    cw     = (d == 1) ? 16 : 10;
    rw     = (d == 1) ? 16 : 8;
    dv     = (d == 1) ? 1 : 2;
    nss    = (d == 1) ? 1 : 4;
    mask_c = 16'((32'h1 << cw) - 32'h1);
    mask_r = 16'((32'h1 << rw) - 32'h1);
    rd     = ((((cmd & mask_c) >> (cw - 2)) & 16'h0003) == 16'h0003);
    eff    = (int'(sel) < nss) ? int'(sel) : 0;
    exp_ss = 4'hF & ~(4'h1 << eff);
    exp_done = 2 + dv * (2 + 2 * cw) + (rd ? 2 * dv * rw : 0);
    n_rise = cw + (rd ? rw : 0);
    exp_w  = 32'(cmd & mask_c) << (rd ? rw : 0);
    exp_rd = rd ? (resp & mask_r) : last_rd[d];
    cur = d; slv_resp = resp; slv_cw = cw; slv_rw = rw; slv_rises = 0;
    mosi_q.delete(); miso = 1'b0;
    ss_first = -1; ss_last = -1; bad_ss = 0; done_cyc = -1;
    done_cnt = 0; rdv_cnt = 0; err_cnt = 0; got_w = 32'h0;
    @(negedge clk);
    cmd_drv = cmd; sel_drv = sel; req_v[d] = 1'b1;
    @(posedge clk);
    lim = exp_done + (inject ? 60 : 6);
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        req_v[d] = 1'b0;
        chk("busy_t1", 32'(o_busy), 32'h1);
        chk("ready_t1", 32'(o_ready), 32'h0);
      end
      if (inject && cyc == 10) begin req_v[d] = 1'b1; cmd_drv = ~cmd; end
      if (inject && cyc == 11) req_v[d] = 1'b0;
      if (o_ss !== 4'hF) begin
        if (ss_first < 0) ss_first = cyc;
        ss_last = cyc;
        if (o_ss !== exp_ss) bad_ss++;
      end
      if (o_err) err_cnt++;
      if (o_rdv) rdv_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("rd_data", 32'(o_rd), 32'(exp_rd));
          chk("rd_valid", 32'(o_rdv), 32'(rd));
          chk("ready_done", 32'(o_ready), 32'h1);
          chk("busy_done", 32'(o_busy), 32'h0);
        end
      end
    end
    foreach (mosi_q[i]) got_w = (got_w << 1) | 32'(mosi_q[i]);
    chk("done_cyc", 32'(done_cyc), 32'(exp_done));
    chk("done_cnt", 32'(done_cnt), 32'h1);
    chk("ss_first", 32'(ss_first), 32'h2);
    chk("ss_last", 32'(ss_last), 32'(exp_done - 1));
    chk("ss_pattern", 32'(bad_ss), 32'h0);
    chk("rdv_cnt", 32'(rdv_cnt), rd ? 32'h1 : 32'h0);
    chk("err_cnt", 32'(err_cnt), 32'h0);
    chk("sclk_rises", 32'(mosi_q.size()), 32'(n_rise));
    chk("mosi_bits", got_w, exp_w);
    chk("rd_hold", 32'(o_rd), 32'(exp_rd));
    last_rd[d] = exp_rd;
  endtask

  task automatic run_timeout();
    int err_cyc, err_cnt, ss_low, done_cnt;
    err_cyc = -1; err_cnt = 0; ss_low = 0; done_cnt = 0;
    cur = 0; sready = 1'b0;
    @(negedge clk);
    cmd_drv = 16'h02A5; sel_drv = 2'd1; req_v[0] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_v[0] = 1'b0;
      if (o_ss !== 4'hF) ss_low++;
      if (o_done) done_cnt++;
      if (o_err) begin
        err_cnt++;
        if (err_cyc < 0) begin
          err_cyc = cyc;
          chk("to_ready", 32'(o_ready), 32'h1);
          chk("to_busy", 32'(o_busy), 32'h0);
        end
      end
    end
    chk("to_cycle", 32'(err_cyc), 32'd9);
    chk("to_pulses", 32'(err_cnt), 32'h1);
    chk("to_ss_quiet", 32'(ss_low), 32'h0);
    chk("to_no_done", 32'(done_cnt), 32'h0);
    sready = 1'b1;
  endtask

  initial begin
    logic [15:0] rc, rr;
    int rd_sel;
    rst_n = 1'b0; req_v = 2'b00; cmd_drv = 16'h0; sel_drv = 2'd0;
    sready = 1'b1; miso = 1'b0; cur = 0; n_vec = 0; n_err = 0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    slv_resp = 16'h0; slv_cw = 10; slv_rw = 8; slv_rises = 0;
    repeat (3) @(negedge clk);
    chk("rst_ss_a", 32'(ss_a), 32'hF);
    chk("rst_ss_b", 32'(ss_b), 32'h1);
    chk("rst_sclk_a", 32'(sclk_a), 32'h0);
    chk("rst_mosi_a", 32'(mosi_a), 32'h0);
    chk("rst_busy_a", 32'(bus_a.busy), 32'h0);
    chk("rst_ready_a", 32'(bus_a.req_ready), 32'h1);
    chk("rst_pulses_a", {29'h0, bus_a.done, bus_a.rd_valid, bus_a.err_timeout}, 32'h0);
    chk("rst_rd_b", 32'(bus_b.rd_data), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(0, 16'h02A5, 2'd0, 16'h0000, 1'b0);
    run_xfer(0, 16'h03C0, 2'd0, 16'h00A5, 1'b0);
    run_timeout();
    run_xfer(0, 16'h00F3, 2'd2, 16'h0000, 1'b1);

    // Abort a transfer mid-TX while sclk is high.
    cur = 0;
    @(negedge clk);
    cmd_drv = 16'h02A5; sel_drv = 2'd0; req_v[0] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_v[0] = 1'b0;
    end
    chk("pre_rst_ss", 32'(o_ss), 32'hE);
    chk("pre_rst_sclk", 32'(o_sclk), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss", 32'(o_ss), 32'hF);
    chk("mid_rst_sclk", 32'(o_sclk), 32'h0);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_rd", 32'(o_rd), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    @(negedge clk);
    run_xfer(0, 16'h0155, 2'd0, 16'h0000, 1'b0);

    run_xfer(1, 16'hC123, 2'd0, 16'hBEEF, 1'b0);

    for (int t = 0; t < 16; t++) begin
      rd_sel = int'($urandom_range(0, 1));
      rc = 16'($urandom);
      rr = 16'($urandom);
      run_xfer(rd_sel, rc, 2'($urandom_range(0, 3)), rr, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
